drawer_loader: RTL and testbench

DRAWER_LOADER -- requirements
Module: drawer_loader

---
 rtl/drawer_pkg.sv | 18 +
 rtl/pixel_assembler.sv | 36 +++
 rtl/drawer_loader.sv | 154 +++++++++++++++
 tb/tb_drawer_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drawer_pkg.sv
// Shared definitions for the drawer subsystem: memory geometry, pixel width
// and the loader's state encoding.
package drawer_pkg;

    localparam int DRAWER_DEPTH  = 16;
    localparam int DRAWER_ADDR_W = 4;
    localparam int PIXEL_W       = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD1,
        ST_LOAD2,
        ST_SETTLE,
        ST_COMPARE,
        ST_DRAW
    } loadState_t;

endpackage

// File: rtl/pixel_assembler.sv
// Packs a B,G,R byte stream into 24-bit pixels. pixelValid is a
// combinational strobe on the handshake that carries the third byte, so the
// caller can register the finished pixel on that same edge.
module pixel_assembler
    import drawer_pkg::*;
(
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byteAccept,
    input  logic [7:0]         byteData,
    output logic [PIXEL_W-1:0] pixel,
    output logic               pixelValid
);

    logic [1:0]  byteCnt;
    logic [15:0] lowBytes;

    assign pixelValid = byteAccept && (byteCnt == 2'd2);
    assign pixel      = {byteData, lowBytes};

    // Byte counter and storage for the first two bytes of the current pixel
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            byteCnt  <= 2'd0;
            lowBytes <= 16'd0;
        end else if (clear) begin
            byteCnt <= 2'd0;
        end else if (byteAccept) begin
            byteCnt <= (byteCnt == 2'd2) ? 2'd0 : byteCnt + 2'd1;
            if (byteCnt == 2'd0) lowBytes[7:0]  <= byteData;
            if (byteCnt == 2'd1) lowBytes[15:8] <= byteData;
        end
    end

endmodule

// File: rtl/drawer_loader.sv
// Loads two images into drawer memories 1 and 2 from a byte stream, waits a
// settle period, sweeps memory 3 in compare mode, then enables VGA drawing.
module drawer_loader
    import drawer_pkg::*;
#(
    parameter int DEPTH    = DRAWER_DEPTH,
    parameter int ADDR_W   = DRAWER_ADDR_W,
    parameter int CMP_HOLD = 2,
    parameter int SETTLE   = 5
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic [ADDR_W-1:0]  address,
    output logic               wren1,
    output logic               wren2,
    output logic               wren3,
    output logic [PIXEL_W-1:0] data1,
    output logic [PIXEL_W-1:0] data2,
    output logic               enable,
    output logic               busy
);

    localparam int HOLD_MAX = (SETTLE > CMP_HOLD) ? SETTLE : CMP_HOLD;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(CMP_HOLD - 1);

    loadState_t         state, nextState;
    logic [ADDR_W-1:0]  pixIdx;
    logic [CNT_W-1:0]   waitCnt;
    logic               loadStart;
    logic               byteAccept;
    logic               pixelValid;
    logic [PIXEL_W-1:0] pixel;

    assign byteAccept = byte_valid && byte_ready;

    pixel_assembler uAsm (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .clear      (loadStart),
        .byteAccept (byteAccept),
        .byteData   (byte_data),
        .pixel      (pixel),
        .pixelValid (pixelValid)
    );

    // State register
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nextState;
    end

    // Next-state decode and state-derived outputs. Phase changes key off the
    // registered write pulse so the last write is visible before leaving.
    always_comb begin
        nextState  = state;
        byte_ready = 1'b0;
        wren3      = 1'b0;
        enable     = 1'b0;
        busy       = 1'b1;
        loadStart  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    nextState = ST_LOAD1;
                    loadStart = 1'b1;
                end
            end
            ST_LOAD1: begin
                byte_ready = 1'b1;
                if (wren1 && address == LAST_ADDR) nextState = ST_LOAD2;
            end
            ST_LOAD2: begin
                byte_ready = 1'b1;
                if (wren2 && address == LAST_ADDR) nextState = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (waitCnt == SETTLE_LAST) nextState = ST_COMPARE;
            end
            ST_COMPARE: begin
                wren3 = 1'b1;
                if (waitCnt == HOLD_LAST && address == LAST_ADDR) nextState = ST_DRAW;
            end
            ST_DRAW: begin
                busy   = 1'b0;
                enable = 1'b1;
                if (start) begin
                    nextState = ST_LOAD1;
                    loadStart = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Write pulses, write data, shared address and phase counters
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            address <= '0;
            data1   <= '0;
            data2   <= '0;
            wren1   <= 1'b0;
            wren2   <= 1'b0;
            pixIdx  <= '0;
            waitCnt <= '0;
        end else begin
            wren1 <= 1'b0;
            wren2 <= 1'b0;
            case (state)
                ST_IDLE, ST_DRAW: begin
                    if (loadStart) pixIdx <= '0;
                end
                ST_LOAD1, ST_LOAD2: begin
                    if (pixelValid) begin
                        address <= pixIdx;
                        pixIdx  <= pixIdx + ADDR_W'(1);
                        if (state == ST_LOAD1) begin
                            wren1 <= 1'b1;
                            data1 <= pixel;
                        end else begin
                            wren2 <= 1'b1;
                            data2 <= pixel;
                        end
                    end
                    if (state == ST_LOAD1 && nextState == ST_LOAD2) pixIdx <= '0;
                    if (nextState == ST_SETTLE) begin
                        address <= '0;
                        waitCnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    waitCnt <= (nextState == ST_COMPARE) ? '0 : waitCnt + CNT_W'(1);
                end
                ST_COMPARE: begin
                    if (waitCnt == HOLD_LAST) begin
                        waitCnt <= '0;
                        if (address != LAST_ADDR) address <= address + ADDR_W'(1);
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_drawer_loader.sv
// Scoreboard bench for drawer_loader: the driver pushes expected writes and
// compare addresses computed from the byte stream; the monitor pops and
// compares whenever a write enable is seen.
module tb_drawer_loader;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int CMP_HOLD = 2;
    localparam int SETTLE   = 5;
    localparam int NBYTES   = 3 * 2 * DEPTH;

    logic              clk50 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic [ADDR_W-1:0] address;
    logic              wren1, wren2, wren3;
    logic [23:0]       data1, data2;
    logic              enable, busy;

    drawer_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CMP_HOLD(CMP_HOLD), .SETTLE(SETTLE)) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .address    (address),
        .wren1      (wren1),
        .wren2      (wren2),
        .wren3      (wren3),
        .data1      (data1),
        .data2      (data2),
        .enable     (enable),
        .busy       (busy)
    );

    always #5 clk50 = ~clk50;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        exp1[$];
    wr_t        exp2[$];
    int         exp3[$];
    logic [7:0] stream[NBYTES];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " address"},    32'(address),    0);
        check({tag, " data1"},      32'(data1),      0);
        check({tag, " data2"},      32'(data2),      0);
        check({tag, " wren"},       32'({wren1, wren2, wren3}), 0);
        check({tag, " enable"},     32'(enable),     0);
        check({tag, " byte_ready"}, 32'(byte_ready), 0);
        check({tag, " busy"},       32'(busy),       0);
    endtask

    task automatic fillStream(input bit incr);
        for (int i = 0; i < NBYTES; i++) stream[i] = incr ? 8'(i) : 8'($urandom);
    endtask

    // Reference: pixel p is bytes 3p..3p+2 little-end first; first DEPTH
    // pixels go to memory 1, the rest to memory 2; compare visits each
    // address CMP_HOLD times in order.
    task automatic loadExpect();
        wr_t w;
        exp1.delete();
        exp2.delete();
        exp3.delete();
        for (int p = 0; p < 2 * DEPTH; p++) begin
            w.addr = p % DEPTH;
            w.data = int'({stream[3*p+2], stream[3*p+1], stream[3*p]});
            if (p < DEPTH) exp1.push_back(w);
            else           exp2.push_back(w);
        end
        for (int a = 0; a < DEPTH; a++)
            for (int h = 0; h < CMP_HOLD; h++) exp3.push_back(a);
    endtask

    task automatic idleCheck(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk50);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            check("idle byte_ready", 32'(byte_ready), 0);
            check("idle busy", 32'(busy), 0);
        end
        @(negedge clk50);
        byte_valid = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk50);
        start = 1'b1;
        @(negedge clk50);
        start = 1'b0;
        check("start enable", 32'(enable), 0);
        check("start byte_ready", 32'(byte_ready), 1);
        check("start busy", 32'(busy), 1);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
    task automatic feed(input int mode, input int nBytes, input bit injectStart);
        int  idx = 0;
        int  cyc = 0;
        bit  tog = 1'b1;
        bit  v;
        bit  injected = 1'b0;
        while (idx < nBytes && cyc < 4000) begin
            @(negedge clk50);
            start = 1'b0;
            if (injectStart && !injected && idx == 60) begin
                start    = 1'b1;
                injected = 1'b1;
            end
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            byte_valid = v;
            byte_data  = v ? stream[idx] : 8'($urandom);
            if (v && byte_ready) idx++;
            cyc++;
        end
        @(negedge clk50);
        byte_valid = 1'b0;
        start      = 1'b0;
        check("bytes accepted", 32'(idx), 32'(nBytes));
    endtask

    task automatic waitDraw(input bit injectCmp);
        int n = 0;
        bit done = 1'b0;
        while (!enable && n < 400) begin
            @(negedge clk50);
            start = injectCmp && wren3 && !done;
            if (start) done = 1'b1;
            n++;
        end
        @(negedge clk50);
        start = 1'b0;
        check("reached draw enable", 32'(enable), 1);
        check("draw busy", 32'(busy), 0);
        check("draw byte_ready", 32'(byte_ready), 0);
        check("pending expectations", 32'(exp1.size() + exp2.size() + exp3.size()), 0);
    endtask

    // Monitor: pops expectations on every write/compare cycle
    initial begin : monitor
        bit  pw1 = 1'b0, pw2 = 1'b0, pw3 = 1'b0;
        int  cyc = 0;
        int  lastW2 = -1000;
        wr_t w;
        int  a;
        forever begin
            @(negedge clk50);
            cyc++;
            if (wren1) begin
                check("wren1 width", 32'(pw1), 0);
                if (exp1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected wren1: addr %0h data1 %0h, none expected", address, data1);
                end else begin
                    w = exp1.pop_front();
                    check("data1", 32'(data1), w.data);
                    check("addr1", 32'(address), w.addr);
                end
            end
            if (wren2) begin
                lastW2 = cyc;
                check("wren2 width", 32'(pw2), 0);
                if (exp2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected wren2: addr %0h data2 %0h, none expected", address, data2);
                end else begin
                    w = exp2.pop_front();
                    check("data2", 32'(data2), w.data);
                    check("addr2", 32'(address), w.addr);
                end
            end
            if (wren3 && !pw3) check("settle gap", 32'(cyc - lastW2), 32'(SETTLE + 1));
            if (wren3) begin
                if (exp3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected wren3: addr %0h, none expected", address);
                end else begin
                    a = exp3.pop_front();
                    check("compare addr", 32'(address), a);
                end
            end
            if (!wren3 && pw3) begin
                check("enable after compare", 32'(enable), 1);
                check("busy after compare", 32'(busy), 0);
            end
            pw1 = wren1;
            pw2 = wren2;
            pw3 = wren3;
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        #12;
        checkAllZero("reset");
        @(negedge clk50);
        rst_n = 1'b1;
        idleCheck(8);

        // Incrementing stream, back-to-back bytes, from IDLE
        fillStream(1'b1);
        loadExpect();
        pulseStart();
        feed(0, NBYTES, 1'b0);
        waitDraw(1'b0);

        // Same stream, valid every other cycle, from DRAW, with start pokes
        // in LOAD2 and COMPARE that must be ignored
        fillStream(1'b1);
        loadExpect();
        pulseStart();
        feed(1, NBYTES, 1'b1);
        waitDraw(1'b1);

        // Random data with random valid gaps
        fillStream(1'b0);
        loadExpect();
        pulseStart();
        feed(2, NBYTES, 1'b0);
        waitDraw(1'b0);

        // Reset mid-load after 40 bytes
        fillStream(1'b0);
        loadExpect();
        pulseStart();
        feed(2, 40, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        exp1.delete();
        exp2.delete();
        exp3.delete();
        @(negedge clk50);
        @(negedge clk50);
        rst_n = 1'b1;
        idleCheck(6);

        // Full reload after reset
        fillStream(1'b1);
        loadExpect();
        pulseStart();
        feed(2, NBYTES, 1'b0);
        waitDraw(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
